// File: rtl/frame_sync_pkg.sv
// frame_sync_pkg: types and constants shared by the frame sync controller,
// its shadow RAM and the renderer.
//   state_e        controller states (IDLE, COPY, RESUME)
//   OVERRUN_CNT_W  width of the optional overrun counter
//   DEF_COPY_BASE  first data-memory word of the scene descriptor window
//   DEF_COPY_LEN   descriptor window length in 16-bit words
//   buf_aw()       shadow buffer address width for a given window length
package frame_sync_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COPY   = 2'd1,
    RESUME = 2'd2
  } state_e;

  localparam int          OVERRUN_CNT_W  = 8;
  localparam int          DEF_DATA_WIDTH = 13;
  localparam logic [12:0] DEF_COPY_BASE  = 13'h1000;
  localparam int          DEF_COPY_LEN   = 256;

  // A one-word window still needs a one-bit address.
  function automatic int buf_aw(input int len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

endpackage

// File: rtl/frame_sync_ctrl_shadow_ram.sv
// shadow_ram: simple dual-port RAM, 2**AW x DW.
//   clk, rst_n        clock, async active-low reset (read register only)
//   we, waddr, wdata  synchronous write port
//   raddr, rdata      registered read port, 1-cycle latency
// Array contents are not reset.
module shadow_ram #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else        rdata <= mem_q[raddr];
  end

endmodule

// File: rtl/frame_sync_ctrl.sv
// frame_sync_ctrl: once per frame, if the CPU is halted on WAIT, copies the
// scene descriptor window of CPU data memory into a shadow buffer, then
// pulses resume / frame_ready.
//   clk, reset_n             clock, async active-low reset
//   frame_tick, cpu_wait     vblank pulse, CPU halted flag
//   resume, frame_ready      one-cycle pulses after a complete copy
//   mem_sel, mem_rd_addr     data-memory read port ownership and address
//   mem_rd_data              combinational data-memory read data
//   busy                     copy in progress
//   buf_rd_addr/_data        renderer read port, 1-cycle latency
// Optional (macro FRAME_SYNC_OVERRUN_CNT_EN): overrun_cnt saturating counter
// of frame ticks that could not start a copy, cleared by overrun_clr.
//
// state  | meaning
// IDLE   | waiting for frame_tick with the CPU halted
// COPY   | one descriptor word copied per cycle
// RESUME | one-cycle resume / frame_ready pulse
module frame_sync_ctrl
  import frame_sync_pkg::*;
#(
  parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] COPY_BASE  = DATA_WIDTH'(DEF_COPY_BASE),
  parameter int                    COPY_LEN   = DEF_COPY_LEN,
  parameter int                    BUF_AW     = buf_aw(COPY_LEN)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  frame_tick,
  input  logic                  cpu_wait,
  output logic                  resume,
  output logic                  mem_sel,
  output logic [DATA_WIDTH-1:0] mem_rd_addr,
  input  logic [15:0]           mem_rd_data,
  output logic                  frame_ready,
  output logic                  busy,
  input  logic [BUF_AW-1:0]     buf_rd_addr,
  output logic [15:0]           buf_rd_data
`ifdef FRAME_SYNC_OVERRUN_CNT_EN
  ,
  input  logic                     overrun_clr,
  output logic [OVERRUN_CNT_W-1:0] overrun_cnt
`endif
);

  localparam logic [BUF_AW-1:0] LAST_CNT = BUF_AW'(COPY_LEN - 1);

  state_e                state_q;
  logic [BUF_AW-1:0]     cnt_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic                  mem_sel_q, busy_q, resume_q, ready_q;

  // The read address is registered alongside cnt_q so that in COPY it always
  // equals COPY_BASE + cnt_q without an adder on the output path.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= COPY_BASE;
      mem_sel_q <= 1'b0;
      busy_q    <= 1'b0;
      resume_q  <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      resume_q <= 1'b0;
      ready_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (frame_tick && cpu_wait) begin
            state_q   <= COPY;
            cnt_q     <= '0;
            addr_q    <= COPY_BASE;
            mem_sel_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        COPY: begin
          cnt_q  <= cnt_q + BUF_AW'(1);
          addr_q <= addr_q + DATA_WIDTH'(1);
          if (cnt_q == LAST_CNT) begin
            state_q   <= RESUME;
            addr_q    <= COPY_BASE;
            mem_sel_q <= 1'b0;
            busy_q    <= 1'b0;
            resume_q  <= 1'b1;
            ready_q   <= 1'b1;
          end
        end
        RESUME:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign resume      = resume_q;
  assign frame_ready = ready_q;
  assign mem_sel     = mem_sel_q;
  assign busy        = busy_q;
  assign mem_rd_addr = addr_q;

  shadow_ram #(
    .AW (BUF_AW),
    .DW (16)
  ) u_shadow_ram (
    .clk   (clk),
    .rst_n (reset_n),
    .we    (state_q == COPY),
    .waddr (cnt_q),
    .wdata (mem_rd_data),
    .raddr (buf_rd_addr),
    .rdata (buf_rd_data)
  );

`ifdef FRAME_SYNC_OVERRUN_CNT_EN
  logic                     overrun_evt;
  logic [OVERRUN_CNT_W-1:0] ovr_q, ovr_d;

  // Any tick outside IDLE, or a tick in IDLE while the CPU is still running.
  assign overrun_evt = frame_tick && ((state_q != IDLE) || !cpu_wait);

  always_comb begin
    ovr_d = ovr_q;
    if (overrun_clr)                      ovr_d = '0;
    else if (overrun_evt && (ovr_q != '1)) ovr_d = ovr_q + OVERRUN_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ovr_q <= '0;
    else          ovr_q <= ovr_d;
  end

  assign overrun_cnt = ovr_q;
`endif

endmodule
